// File: rtl/rv32_mem_responder.sv
// rv32_mem_responder: single-ported word RAM answering the rv32 instruction and data buses, data first.
// Latency: ready pulses WAIT_STATES+2 cycles after the IDLE cycle that sampled the request.
// Backpressure: one access in flight; requests are sampled only in IDLE and held by the initiator until ready.
module rv32_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  // Byte span of the RAM, kept one bit wider so the range compare never wraps.
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESPOND} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            grant_data;
  logic [AW-1:0]   idx_q;
  logic            hit_q;
  logic            is_write_q;
  logic [3:0]      mask_q;
  logic [31:0]     wval_q;
  logic            ram_we;

  logic [31:0]     mem [DEPTH_WORDS];

  // Offsets from the RAM base wrap modulo 2^32, so addresses below the base land far out of range.
  logic [31:0]     instr_off;
  logic [31:0]     data_off;
  logic            instr_hit;
  logic            data_hit;

  assign instr_off = instr_address_in - BASE_ADDRESS;
  assign data_off  = data_address_in - BASE_ADDRESS;
  assign instr_hit = {1'b0, instr_off} < SPAN;
  assign data_hit  = {1'b0, data_off} < SPAN;

  // The write commits only on the edge closing ACCESS; reset low blocks it.
  assign ram_we = (state == ACCESS) && is_write_q && hit_q && reset_n;

  // RAM write port: byte-masked store, contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) begin
          mem[idx_q][8*i +: 8] <= wval_q[8*i +: 8];
        end
      end
    end
  end

  // Arbitration, wait-state sequencing and registered read/ready outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= IDLE;
      wait_cnt             <= 4'd0;
      grant_data           <= 1'b0;
      idx_q                <= '0;
      hit_q                <= 1'b0;
      is_write_q           <= 1'b0;
      mask_q               <= 4'd0;
      wval_q               <= 32'd0;
      instr_read_value_out <= 32'd0;
      instr_ready_out      <= 1'b0;
      data_read_value_out  <= 32'd0;
      data_ready_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_read_in || data_write_in) begin
            // A read with write also high is handled as a plain write.
            grant_data <= 1'b1;
            idx_q      <= data_off[AW+1:2];
            hit_q      <= data_hit;
            is_write_q <= data_write_in;
            mask_q     <= data_write_mask_in;
            wval_q     <= data_write_value_in;
          end else if (instr_read_in) begin
            grant_data <= 1'b0;
            idx_q      <= instr_off[AW+1:2];
            hit_q      <= instr_hit;
            is_write_q <= 1'b0;
          end
          if (data_read_in || data_write_in || instr_read_in) begin
            if (WAIT_STATES > 0) begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end else begin
              state    <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACCESS: begin
          if (grant_data) begin
            data_ready_out <= 1'b1;
            if (!is_write_q && hit_q) begin
              data_read_value_out <= mem[idx_q];
            end
          end else begin
            instr_ready_out <= 1'b1;
            if (hit_q) begin
              instr_read_value_out <= mem[idx_q];
            end
          end
          state <= RESPOND;
        end
        RESPOND: begin
          instr_ready_out      <= 1'b0;
          data_ready_out       <= 1'b0;
          instr_read_value_out <= 32'd0;
          data_read_value_out  <= 32'd0;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
